// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, redirect target select, IF/ID
// pipeline register and the terminate -> drain -> halted state machine.
module fetch_stage #(
  parameter int          WORD         = 32,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          DRAIN_CYCLES = 3
) (
  input  logic            clk,
  input  logic            rst,
  output logic [WORD-1:0] imem_addr,
  input  logic [WORD-1:0] imem_data,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic            jump_taken,
  input  logic            is_jr,
  input  logic            terminate,
  input  logic [WORD-1:0] reg_rs_d,
  output logic [WORD-1:0] instr_d,
  output logic [WORD-1:0] pc_plus4_d,
  output logic            valid_d,
  output logic            halted
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [WORD-1:0] pc, pc_nx, pc_plus4;
  logic [WORD-1:0] instr_nx, pp4_nx;
  logic            valid_nx;
  logic [WORD-1:0] br_tgt, j_tgt, redir_tgt;
  logic            redirect;

  assign imem_addr = pc;
  assign pc_plus4  = pc + WORD'(4);

  // Redirect targets from the IF/ID contents; a jump outranks a branch.
  always_comb begin
    br_tgt    = pc_plus4_d + {{(WORD-18){instr_d[15]}}, instr_d[15:0], 2'b00};
    j_tgt     = {pc_plus4_d[WORD-1:28], instr_d[25:0], 2'b00};
    redir_tgt = br_tgt;
    if (is_jr)           redir_tgt = reg_rs_d;
    else if (jump_taken) redir_tgt = j_tgt;
  end

  // Decoder outputs only count for a real, non-stalled ID instruction.
  assign redirect = valid_d & ~stall & (branch_taken | jump_taken);

  // Next-state, PC and IF/ID update; everything holds by default.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pc_nx    = pc;
    instr_nx = instr_d;
    pp4_nx   = pc_plus4_d;
    valid_nx = valid_d;
    unique case (state)
      RUN: begin
        if (terminate && valid_d && !stall) begin
          state_nx = DRAIN;
          cnt_nx   = CW'(DRAIN_CYCLES - 1);
          instr_nx = '0;
          valid_nx = 1'b0;
        end else if (stall) begin
          // load-use hazard: freeze PC and IF/ID
        end else if (redirect) begin
          // no delay slot: squash the wrong-path fetch
          pc_nx    = redir_tgt;
          instr_nx = '0;
          valid_nx = 1'b0;
        end else begin
          pc_nx    = pc_plus4;
          instr_nx = imem_data;
          pp4_nx   = pc_plus4;
          valid_nx = 1'b1;
        end
      end
      DRAIN: begin
        instr_nx = '0;
        valid_nx = 1'b0;
        if (cnt == '0) state_nx = HALTED;
        else           cnt_nx   = cnt - CW'(1);
      end
      HALTED: begin
        instr_nx = '0;
        valid_nx = 1'b0;
      end
      default: state_nx = RUN;
    endcase
  end

  // State, PC, IF/ID and the sticky halted flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      cnt        <= '0;
      pc         <= RESET_PC[WORD-1:0];
      instr_d    <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      pc         <= pc_nx;
      instr_d    <= instr_nx;
      pc_plus4_d <= pp4_nx;
      valid_d    <= valid_nx;
      halted     <= (state_nx == HALTED);
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: the bench plays both instruction memory
// and decoder, and checks PC / IF/ID / halted against hand-computed values.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken, jump_taken, is_jr, terminate;
  logic [31:0] imem_addr, imem_data, reg_rs_d, instr_d, pc_plus4_d;
  logic        valid_d, halted;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  fetch_stage #(.WORD(32), .RESET_PC(32'h0), .DRAIN_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .branch_taken(branch_taken), .jump_taken(jump_taken),
    .is_jr(is_jr), .terminate(terminate), .reg_rs_d(reg_rs_d),
    .instr_d(instr_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d),
    .halted(halted)
  );

  // Instruction memory: distinct word per address plus a few planted opcodes.
  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0000_000C: mem = 32'h1000_0003; // BEQ +3
      32'h1000_0004: mem = 32'h0800_0040; // J 0x40
      32'h0000_0234: mem = 32'h0800_0100; // J 0x100 (branch field also 0x100)
      32'h0000_0400: mem = 32'h1000_0010; // BEQ +0x10
      32'h0000_0444: mem = 32'h1000_FFFE; // BEQ -2
      default:       mem = 32'hAB00_0000 ^ a;
    endcase
  endfunction

  assign imem_data = mem(imem_addr);

  // Advance one edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    stall = 0; branch_taken = 0; jump_taken = 0; is_jr = 0; terminate = 0;
    reg_rs_d = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1; clr();
    step(); step();
    checks++;
    if ({imem_addr, instr_d, pc_plus4_d, valid_d, halted} !== {32'h0, 32'h0, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: pc=%h instr=%h pp4=%h v=%b h=%b, want all zero",
               imem_addr, instr_d, pc_plus4_d, valid_d, halted);
    end
    rst = 0;
  endtask

  task automatic test_run();
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if ({imem_addr, instr_d, pc_plus4_d, valid_d} !== {32'(4*i), mem(32'(4*(i-1))), 32'(4*i), 1'b1}) begin
        errors++;
        $display("FAIL run[%0d]: pc=%h instr=%h pp4=%h v=%b, want pc=%h instr=%h pp4=%h v=1",
                 i, imem_addr, instr_d, pc_plus4_d, valid_d, 4*i, mem(32'(4*(i-1))), 4*i);
      end
    end
  endtask

  task automatic test_branch();
    step(); // BEQ from 0xC now in IF/ID
    checks++;
    if ({imem_addr, instr_d, pc_plus4_d, valid_d} !== {32'h10, 32'h1000_0003, 32'h10, 1'b1}) begin
      errors++;
      $display("FAIL beq_in_id: pc=%h instr=%h pp4=%h v=%b, want 10 10000003 10 1",
               imem_addr, instr_d, pc_plus4_d, valid_d);
    end
    branch_taken = 1;
    step();
    checks++;
    if ({imem_addr, instr_d, valid_d} !== {32'h1C, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL beq_taken: pc=%h instr=%h v=%b, want 1c 0 0", imem_addr, instr_d, valid_d);
    end
    branch_taken = 0;
    step();
    checks++;
    if ({imem_addr, instr_d, pc_plus4_d, valid_d} !== {32'h20, mem(32'h1C), 32'h20, 1'b1}) begin
      errors++;
      $display("FAIL beq_target_fetch: pc=%h instr=%h pp4=%h v=%b, want 20 %h 20 1",
               imem_addr, instr_d, pc_plus4_d, valid_d, mem(32'h1C));
    end
    // Return to 0xC via JR so the same BEQ can be seen not-taken.
    jump_taken = 1; is_jr = 1; reg_rs_d = 32'hC;
    step();
    checks++;
    if ({imem_addr, valid_d} !== {32'hC, 1'b0}) begin
      errors++;
      $display("FAIL jr_back: pc=%h v=%b, want c 0", imem_addr, valid_d);
    end
    clr();
    step();
    step(); // BEQ not taken: fetch continues without a bubble
    checks++;
    if ({imem_addr, instr_d, pc_plus4_d, valid_d} !== {32'h14, mem(32'h10), 32'h14, 1'b1}) begin
      errors++;
      $display("FAIL beq_not_taken: pc=%h instr=%h pp4=%h v=%b, want 14 %h 14 1",
               imem_addr, instr_d, pc_plus4_d, valid_d, mem(32'h10));
    end
  endtask

  task automatic test_jumps();
    jump_taken = 1; is_jr = 1; reg_rs_d = 32'h1000_0004;
    step();
    clr();
    step();
    checks++;
    if ({imem_addr, instr_d, pc_plus4_d} !== {32'h1000_0008, 32'h0800_0040, 32'h1000_0008}) begin
      errors++;
      $display("FAIL j_setup: pc=%h instr=%h pp4=%h, want 10000008 08000040 10000008",
               imem_addr, instr_d, pc_plus4_d);
    end
    jump_taken = 1;
    step();
    checks++;
    if ({imem_addr, valid_d} !== {32'h1000_0100, 1'b0}) begin
      errors++;
      $display("FAIL j_target: pc=%h v=%b, want 10000100 0", imem_addr, valid_d);
    end
    clr();
    step();
    jump_taken = 1; is_jr = 1; reg_rs_d = 32'h0000_0234;
    step();
    checks++;
    if ({imem_addr, valid_d} !== {32'h234, 1'b0}) begin
      errors++;
      $display("FAIL jr_target: pc=%h v=%b, want 234 0", imem_addr, valid_d);
    end
    clr();
    step(); // J 0x100 at pc_plus4_d=0x238: jump 0x400 vs branch 0x638
    branch_taken = 1; jump_taken = 1;
    step();
    checks++;
    if (imem_addr !== 32'h400) begin
      errors++;
      $display("FAIL jump_beats_branch: pc=%h, want 400", imem_addr);
    end
    clr();
    step();
    checks++;
    if ({imem_addr, instr_d, valid_d} !== {32'h404, 32'h1000_0010, 1'b1}) begin
      errors++;
      $display("FAIL after_jump: pc=%h instr=%h v=%b, want 404 10000010 1",
               imem_addr, instr_d, valid_d);
    end
  endtask

  task automatic test_stall();
    stall = 1; branch_taken = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({imem_addr, instr_d, pc_plus4_d, valid_d} !== {32'h404, 32'h1000_0010, 32'h404, 1'b1}) begin
        errors++;
        $display("FAIL stall[%0d]: pc=%h instr=%h pp4=%h v=%b, want 404 10000010 404 1",
                 i, imem_addr, instr_d, pc_plus4_d, valid_d);
      end
    end
    stall = 0;
    step();
    checks++;
    if ({imem_addr, valid_d} !== {32'h444, 1'b0}) begin
      errors++;
      $display("FAIL stall_release_redirect: pc=%h v=%b, want 444 0", imem_addr, valid_d);
    end
    clr();
    step(); // BEQ -2 in IF/ID, pc_plus4_d=0x448
    branch_taken = 1;
    step();
    checks++;
    if (imem_addr !== 32'h440) begin
      errors++;
      $display("FAIL beq_negative: pc=%h, want 440", imem_addr);
    end
    clr();
    step();
    checks++;
    if ({imem_addr, instr_d, valid_d} !== {32'h444, mem(32'h440), 1'b1}) begin
      errors++;
      $display("FAIL after_negative: pc=%h instr=%h v=%b, want 444 %h 1",
               imem_addr, instr_d, valid_d, mem(32'h440));
    end
  endtask

  task automatic test_terminate();
    terminate = 1;
    step(); // acceptance edge
    checks++;
    if ({imem_addr, instr_d, valid_d, halted} !== {32'h444, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL term_accept: pc=%h instr=%h v=%b h=%b, want 444 0 0 0",
               imem_addr, instr_d, valid_d, halted);
    end
    // Stall/redirect requests must be ignored while draining.
    terminate = 0; stall = 1; branch_taken = 1; jump_taken = 1;
    for (int i = 1; i <= 2; i++) begin
      step();
      checks++;
      if ({imem_addr, valid_d, halted} !== {32'h444, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL drain[%0d]: pc=%h v=%b h=%b, want 444 0 0", i, imem_addr, valid_d, halted);
      end
    end
    step();
    checks++;
    if ({imem_addr, valid_d, halted} !== {32'h444, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL halt_edge: pc=%h v=%b h=%b, want 444 0 1", imem_addr, valid_d, halted);
    end
    stall = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({imem_addr, valid_d, halted} !== {32'h444, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL halted_sticky[%0d]: pc=%h v=%b h=%b, want 444 0 1",
                 i, imem_addr, valid_d, halted);
      end
    end
    clr();
  endtask

  task automatic test_reset_mid();
    rst = 1;
    step();
    rst = 0;
    checks++;
    if ({imem_addr, halted, valid_d} !== {32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_from_halt: pc=%h h=%b v=%b, want 0 0 0", imem_addr, halted, valid_d);
    end
    step();
    terminate = 1;
    step(); // accept
    terminate = 0;
    step(); // drain counter now 1
    rst = 1;
    step();
    rst = 0;
    checks++;
    if ({imem_addr, instr_d, valid_d, halted} !== {32'h0, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_drain: pc=%h instr=%h v=%b h=%b, want 0 0 0 0",
               imem_addr, instr_d, valid_d, halted);
    end
    step();
    checks++;
    if ({imem_addr, instr_d, pc_plus4_d, valid_d} !== {32'h4, mem(32'h0), 32'h4, 1'b1}) begin
      errors++;
      $display("FAIL resume_fetch: pc=%h instr=%h pp4=%h v=%b, want 4 %h 4 1",
               imem_addr, instr_d, pc_plus4_d, valid_d, mem(32'h0));
    end
    step(); step(); step();
    checks++;
    if ({imem_addr, halted} !== {32'h10, 1'b0}) begin
      errors++;
      $display("FAIL no_stale_halt: pc=%h h=%b, want 10 0", imem_addr, halted);
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_branch();
    test_jumps();
    test_stall();
    test_terminate();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
